// File: rtl/soc_fifo_sclk_pkg.sv
// rtl/soc_fifo_sclk_pkg.sv - shared constants and default-threshold helpers for soc_fifo_sclk
package soc_fifo_sclk_pkg;

    localparam int AE_THR_DEFAULT = 1;

    // Default almost-full level: one entry short of capacity.
    function automatic int af_thr_default(input int aw);
        return (1 << aw) - 1;
    endfunction

    // Threshold range rules, shared by the top-level elaboration check.
    function automatic bit af_thr_ok(input int aw, input int thr);
        return (thr >= 1) && (thr <= (1 << aw));
    endfunction

    function automatic bit ae_thr_ok(input int aw, input int thr);
        return (thr >= 0) && (thr <= (1 << aw) - 1);
    endfunction

endpackage

// File: rtl/soc_fifo_sclk_ram.sv
// rtl/soc_fifo_sclk_ram.sv - simple dual-port RAM with registered or asynchronous read
module soc_fifo_sclk_ram #(
    parameter int DW       = 8,
    parameter int AW       = 4,
    parameter int ASYNC_RD = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [1 << AW];
    logic [DW-1:0] r_rdata;

    // Write port; storage is never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Registered read port: captures the addressed word on re, otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = (ASYNC_RD != 0) ? r_mem[raddr] : r_rdata;

endmodule

// File: rtl/soc_fifo_sclk.sv
// rtl/soc_fifo_sclk.sv - single-clock FIFO with show-ahead option, count, thresholds and error flags
module soc_fifo_sclk
    import soc_fifo_sclk_pkg::*;
#(
    parameter int DW     = 8,
    parameter int AW     = 4,
    parameter int FWFT   = 0,
    parameter int AF_THR = af_thr_default(AW),
    parameter int AE_THR = AE_THR_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [DW-1:0] din,
    input  logic          push,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   count,
    output logic          ovf,
    output logic          udf,
    input  logic          err_clr
);

    localparam logic [AW:0] L_DEPTH = (AW+1)'(1 << AW);
    localparam logic [AW:0] L_AF    = (AW+1)'(AF_THR);
    localparam logic [AW:0] L_AE    = (AW+1)'(AE_THR);
    localparam logic [AW:0] L_ONE   = (AW+1)'(1);

    if (!af_thr_ok(AW, AF_THR)) begin : g_bad_af_thr
        $error("soc_fifo_sclk: AF_THR out of range 1..2**AW");
    end
    if (!ae_thr_ok(AW, AE_THR)) begin : g_bad_ae_thr
        $error("soc_fifo_sclk: AE_THR out of range 0..2**AW-1");
    end

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic [AW:0] r_count;
    logic        r_full;
    logic        r_empty;
    logic        r_af;
    logic        r_ae;
    logic        r_ovf;
    logic        r_udf;

    logic        w_push_acc;
    logic        w_pop_acc;
    logic        w_we;
    logic        w_re;
    logic [AW:0] w_count_nxt;

    // Acceptance is judged on the registered flags; there is no bypass at either end.
    assign w_push_acc  = push & ~r_full;
    assign w_pop_acc   = pop & ~r_empty;
    assign w_we        = w_push_acc & ~rst & ~flush;
    assign w_re        = w_pop_acc & ~rst & ~flush;
    assign w_count_nxt = r_count + {{AW{1'b0}}, w_push_acc} - {{AW{1'b0}}, w_pop_acc};

    // Pointers, occupancy and flags, all derived from the next count so they never lag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_af    <= 1'b0;
            r_ae    <= 1'b1;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_af    <= ('0 >= L_AF);
            r_ae    <= ('0 <= L_AE);
        end else begin
            if (w_push_acc) begin
                r_wptr <= r_wptr + L_ONE;
            end
            if (w_pop_acc) begin
                r_rptr <= r_rptr + L_ONE;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == L_DEPTH);
            r_empty <= (w_count_nxt == '0);
            r_af    <= (w_count_nxt >= L_AF);
            r_ae    <= (w_count_nxt <= L_AE);
            // A rejected request in the same cycle as err_clr leaves the flag set.
            r_ovf   <= (r_ovf & ~err_clr) | (push & r_full);
            r_udf   <= (r_udf & ~err_clr) | (pop & r_empty);
        end
    end

    soc_fifo_sclk_ram #(
        .DW       (DW),
        .AW       (AW),
        .ASYNC_RD (FWFT)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (w_we),
        .waddr (r_wptr[AW-1:0]),
        .wdata (din),
        .re    (w_re),
        .raddr (r_rptr[AW-1:0]),
        .rdata (dout)
    );

    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign count        = r_count;
    assign ovf          = r_ovf;
    assign udf          = r_udf;

endmodule
